instruction_fetch_unit: RTL and testbench

Instruction fetch stage of the JZJCoreF: owns the program counter, fetches 32-bit instructions from instruction memory over a request/acknowledge handshake, and presents each fetched instruction to decode/execute with a valid/ready handshake. Sits directly upstream of the immediate former, producing `pcOfInstruction` and the U-type immediate `immediateU` that the immediate former consumes for LUI/AUIPC. It also accepts PC redirects from the branch/jump logic.

---
 rtl/instruction_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the program counter, fetches 32-bit words over a
// req/ack memory handshake and presents them downstream with valid/ready.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect -> FAULT).
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memAck,
  input  logic [31:0] memData,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  output logic        instructionValid,
  input  logic        instructionReady,
  output logic [31:0] instruction,
  output logic [31:0] pcOfInstruction,
  output logic [31:0] immediateU,
  output logic        fetchFault
);

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {RESET_WAIT, REQUEST, HOLD, FAULT} fetchState_t;
`else
  typedef enum logic [1:0] {RESET_WAIT, REQUEST, HOLD} fetchState_t;
`endif

  fetchState_t stateReg, stateNext;
  logic [31:0] pcReg, pcNext;
  logic [31:0] instrReg, instrNext;
  logic [31:0] heldPcReg, heldPcNext;
  logic        pendValidReg, pendValidNext;
  logic [31:0] pendTargetReg, pendTargetNext;

  // Fetches are always word aligned; the low target bits never reach the PC.
  logic [31:0] redirectAligned;
  assign redirectAligned = {redirectTarget[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
  logic redirectMisaligned;
  assign redirectMisaligned = redirectValid && (redirectTarget[1:0] != 2'b00);
`else
  logic unusedTargetLsbs;
  assign unusedTargetLsbs = ^redirectTarget[1:0];
`endif

  // State register: reset abandons any outstanding request and drops the held word.
  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg      <= RESET_WAIT;
      pcReg         <= RESET_PC;
      instrReg      <= '0;
      heldPcReg     <= RESET_PC;
      pendValidReg  <= 1'b0;
      pendTargetReg <= '0;
    end else begin
      stateReg      <= stateNext;
      pcReg         <= pcNext;
      instrReg      <= instrNext;
      heldPcReg     <= heldPcNext;
      pendValidReg  <= pendValidNext;
      pendTargetReg <= pendTargetNext;
    end
  end

  // Next-state logic: PC sequencing, redirect capture and ack handling.
  always_comb begin
    stateNext      = stateReg;
    pcNext         = pcReg;
    instrNext      = instrReg;
    heldPcNext     = heldPcReg;
    pendValidNext  = pendValidReg;
    pendTargetNext = pendTargetReg;
    case (stateReg)
      RESET_WAIT: begin
        stateNext = REQUEST;
      end
      REQUEST: begin
`ifdef FETCH_MISALIGN_CHECK_EN
        if (redirectMisaligned) begin
          stateNext     = FAULT;
          pendValidNext = 1'b0;
        end else
`endif
        if (memAck) begin
          if (redirectValid) begin
            // The newest redirect beats any pending one; the acked word is stale.
            pcNext        = redirectAligned;
            pendValidNext = 1'b0;
          end else if (pendValidReg) begin
            pcNext        = pendTargetReg;
            pendValidNext = 1'b0;
          end else begin
            instrNext  = memData;
            heldPcNext = pcReg;
            stateNext  = HOLD;
          end
        end else if (redirectValid) begin
          // memAddr must stay stable until the ack, so park the redirect (last wins).
          pendValidNext  = 1'b1;
          pendTargetNext = redirectAligned;
        end
      end
      HOLD: begin
`ifdef FETCH_MISALIGN_CHECK_EN
        if (redirectMisaligned) begin
          stateNext = FAULT;
        end else
`endif
        if (redirectValid) begin
          // Redirect wins even if the consumer accepts in the same cycle.
          pcNext    = redirectAligned;
          stateNext = REQUEST;
        end else if (instructionReady) begin
          pcNext    = pcReg + 32'd4;
          stateNext = REQUEST;
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      FAULT: begin
        stateNext = FAULT;
      end
`endif
      default: begin
        stateNext = RESET_WAIT;
      end
    endcase
  end

  assign memReq           = (stateReg == REQUEST);
  assign memAddr          = pcReg;
  assign instructionValid = (stateReg == HOLD);
  assign instruction      = instrReg;
  assign pcOfInstruction  = heldPcReg;
  assign immediateU       = {instrReg[31:12], 12'h000};
`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetchFault       = (stateReg == FAULT);
`else
  assign fetchFault       = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit with RESET_PC = 0x100.
module tb_instruction_fetch_unit;
  logic        clock;
  logic        reset;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memData;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic        instructionValid;
  logic        instructionReady;
  logic [31:0] instruction;
  logic [31:0] pcOfInstruction;
  logic [31:0] immediateU;
  logic        fetchFault;

  int total = 0;
  int bad   = 0;

  instruction_fetch_unit #(.RESET_PC(32'h00000100)) dut (
    .clock            (clock),
    .reset            (reset),
    .memReq           (memReq),
    .memAddr          (memAddr),
    .memAck           (memAck),
    .memData          (memData),
    .redirectValid    (redirectValid),
    .redirectTarget   (redirectTarget),
    .instructionValid (instructionValid),
    .instructionReady (instructionReady),
    .instruction      (instruction),
    .pcOfInstruction  (pcOfInstruction),
    .immediateU       (immediateU),
    .fetchFault       (fetchFault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; memAck = 1'b0; memData = '0;
    redirectValid = 1'b0; redirectTarget = '0; instructionReady = 1'b0;
    tick(); tick();
    check("rst_memReq", {31'd0, memReq}, 32'd0);
    check("rst_memAddr", memAddr, 32'h100);
    check("rst_valid", {31'd0, instructionValid}, 32'd0);
    check("rst_instr", instruction, 32'h0);
    check("rst_pcOf", pcOfInstruction, 32'h100);
    check("rst_immU", immediateU, 32'h0);
    check("rst_fault", {31'd0, fetchFault}, 32'd0);

    // Zero-wait fetch of LUI at 0x100
    reset = 1'b0; memAck = 1'b1; memData = 32'h12345037;
    tick();
    check("first_memReq", {31'd0, memReq}, 32'd1);
    check("first_addr", memAddr, 32'h100);
    tick();
    check("first_valid", {31'd0, instructionValid}, 32'd1);
    check("first_memReq_off", {31'd0, memReq}, 32'd0);
    check("first_pcOf", pcOfInstruction, 32'h100);
    check("first_instr", instruction, 32'h12345037);
    check("first_immU", immediateU, 32'h12345000);
    memAck = 1'b0; instructionReady = 1'b1;
    tick();
    instructionReady = 1'b0;
    check("next_memReq", {31'd0, memReq}, 32'd1);
    check("next_addr", memAddr, 32'h104);
    check("next_valid", {31'd0, instructionValid}, 32'd0);

    // Two redirects while 0x104 is unacked: last (0x200) wins, ack data discarded
    redirectValid = 1'b1; redirectTarget = 32'h180;
    tick();
    redirectTarget = 32'h200;
    tick();
    redirectValid = 1'b0;
    check("pend_addr_stable", memAddr, 32'h104);
    check("pend_memReq", {31'd0, memReq}, 32'd1);
    memAck = 1'b1; memData = 32'hDEADBEEF;
    tick();
    check("redir_addr", memAddr, 32'h200);
    check("redir_discard_valid", {31'd0, instructionValid}, 32'd0);
    check("redir_memReq", {31'd0, memReq}, 32'd1);
    memData = 32'h00000293;
    tick();
    memAck = 1'b0;
    check("redir_valid", {31'd0, instructionValid}, 32'd1);
    check("redir_pcOf", pcOfInstruction, 32'h200);
    check("redir_instr", instruction, 32'h00000293);

    // Accept, then memory acks 3 cycles late
    instructionReady = 1'b1;
    tick();
    instructionReady = 1'b0;
    check("late_addr0", memAddr, 32'h204);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("late_addr%0d", i + 1), memAddr, 32'h204);
      check($sformatf("late_req%0d", i + 1), {31'd0, memReq}, 32'd1);
      check($sformatf("late_valid%0d", i + 1), {31'd0, instructionValid}, 32'd0);
    end
    memAck = 1'b1; memData = 32'hABCDE0B7;
    tick();
    memAck = 1'b0;
    check("late_valid", {31'd0, instructionValid}, 32'd1);
    check("late_pcOf", pcOfInstruction, 32'h204);
    check("late_immU", immediateU, 32'hABCDE000);

    // Ready and redirect together in HOLD: redirect wins
    instructionReady = 1'b1; redirectValid = 1'b1; redirectTarget = 32'h300;
    tick();
    instructionReady = 1'b0; redirectValid = 1'b0;
    check("rr_addr", memAddr, 32'h300);
    check("rr_valid", {31'd0, instructionValid}, 32'd0);

    // Redirect arriving on the ack cycle: data dropped, PC goes to 0xFFFFFFFC
    memAck = 1'b1; memData = 32'h0BADF00D; redirectValid = 1'b1; redirectTarget = 32'hFFFFFFFC;
    tick();
    redirectValid = 1'b0;
    check("ackredir_addr", memAddr, 32'hFFFFFFFC);
    check("ackredir_valid", {31'd0, instructionValid}, 32'd0);
    memData = 32'h00100073;
    tick();
    memAck = 1'b0;
    check("top_pcOf", pcOfInstruction, 32'hFFFFFFFC);
    check("top_instr", instruction, 32'h00100073);

    // PC wrap on accept
    instructionReady = 1'b1;
    tick();
    instructionReady = 1'b0;
    check("wrap_addr", memAddr, 32'h0);
    check("wrap_req", {31'd0, memReq}, 32'd1);
    memAck = 1'b1; memData = 32'h11111111;
    tick();
    memAck = 1'b0;
    check("wrap_pcOf", pcOfInstruction, 32'h0);

    // Misaligned redirect from HOLD
    redirectValid = 1'b1; redirectTarget = 32'h202;
    tick();
    redirectValid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis_fault", {31'd0, fetchFault}, 32'd1);
    check("mis_req", {31'd0, memReq}, 32'd0);
    check("mis_valid", {31'd0, instructionValid}, 32'd0);
    memAck = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mis_stuck_req%0d", i), {31'd0, memReq}, 32'd0);
      check($sformatf("mis_stuck_fault%0d", i), {31'd0, fetchFault}, 32'd1);
    end
    memAck = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mis_rst_fault", {31'd0, fetchFault}, 32'd0);
    check("mis_rst_addr", memAddr, 32'h100);
    tick();
    check("mis_rst_req", {31'd0, memReq}, 32'd1);
    memAck = 1'b1; memData = 32'h33333333;
    tick();
    memAck = 1'b0;
    check("mis_rst_valid", {31'd0, instructionValid}, 32'd1);
`else
    check("mis_fault", {31'd0, fetchFault}, 32'd0);
    check("mis_req", {31'd0, memReq}, 32'd1);
    check("mis_addr", memAddr, 32'h200);
    memAck = 1'b1; memData = 32'h22222222;
    tick();
    memAck = 1'b0;
    check("mis_valid", {31'd0, instructionValid}, 32'd1);
    check("mis_pcOf", pcOfInstruction, 32'h200);
`endif

    // Reset while holding an instruction drops it
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_valid", {31'd0, instructionValid}, 32'd0);
    check("midrst_req", {31'd0, memReq}, 32'd0);
    check("midrst_addr", memAddr, 32'h100);
    check("midrst_instr", instruction, 32'h0);
    check("midrst_pcOf", pcOfInstruction, 32'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
